// File: rtl/counter_event_monitor.sv
// Observes a 4-bit counter's RCO/LOAD outputs and queues timestamped event records in a FWFT FIFO.
// Define CNT_MON_EDGE_DETECT_EN to turn level events into rising-edge events.
module counter_event_monitor #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            ENABLE,
    input  logic [3:0]      Q,
    input  logic            RCO,
    input  logic            LOAD,
    output logic            EV_VALID,
    input  logic            EV_READY,
    output logic [1:0]      EV_TYPE,
    output logic [3:0]      EV_Q,
    output logic [TS_W-1:0] EV_TS,
    output logic            FULL,
    output logic            EMPTY,
    output logic            OVERFLOW,
    output logic [7:0]      RCO_CNT
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]      kind;
        logic [3:0]      q;
        logic [TS_W-1:0] ts;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TS_W-1:0] ts;
    logic            rco_ev;
    logic            load_ev;
    logic            push_req;
    logic            push;
    logic            pop;

`ifdef CNT_MON_EDGE_DETECT_EN
    logic rco_d;
    logic load_d;

    // History only advances while capture is enabled, so a level spanning a pause is one event.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rco_d  <= 1'b0;
            load_d <= 1'b0;
        end else if (ENABLE) begin
            rco_d  <= RCO;
            load_d <= LOAD;
        end
    end

    assign rco_ev  = RCO && !rco_d;
    assign load_ev = LOAD && !load_d;
`else
    assign rco_ev  = RCO;
    assign load_ev = LOAD;
`endif

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign EMPTY    = (wr_ptr == rd_ptr);
    assign FULL     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign EV_VALID = !EMPTY;

    assign pop      = EV_VALID && EV_READY;
    assign push_req = ENABLE && (rco_ev || load_ev);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!FULL || pop);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
            RCO_CNT  <= '0;
        end else begin
            if (ENABLE) ts <= ts + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) OVERFLOW <= 1'b1;
            if (ENABLE && rco_ev) RCO_CNT <= RCO_CNT + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{kind: {load_ev, rco_ev}, q: Q, ts: ts};
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        head = '0;
        if (!EMPTY) head = mem[rd_ptr[AW-1:0]];
    end

    assign EV_TYPE = head.kind;
    assign EV_Q    = head.q;
    assign EV_TS   = head.ts;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Self-checking bench for counter_event_monitor: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_counter_event_monitor;

    localparam int DEPTH = 4;
`ifdef CNT_MON_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, rco, load, ev_ready;
    logic [3:0] q;
    logic       ev_valid, full, empty, overflow;
    logic [1:0] ev_type;
    logic [3:0] ev_q;
    logic [7:0] ev_ts, rco_cnt;

    counter_event_monitor #(.DEPTH(DEPTH), .TS_W(8)) dut (
        .clk      (clk),
        .RESET    (rst_n),
        .ENABLE   (enable),
        .Q        (q),
        .RCO      (rco),
        .LOAD     (load),
        .EV_VALID (ev_valid),
        .EV_READY (ev_ready),
        .EV_TYPE  (ev_type),
        .EV_Q     (ev_q),
        .EV_TS    (ev_ts),
        .FULL     (full),
        .EMPTY    (empty),
        .OVERFLOW (overflow),
        .RCO_CNT  (rco_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int q;
        int ts;
    } rec_t;

    rec_t m_q[$];
    int   m_ts, m_cnt;
    bit   m_ovf, m_prev_rco, m_prev_load;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts = 0; m_cnt = 0; m_ovf = 0; m_prev_rco = 0; m_prev_load = 0;
    endtask

    // Applies the sampled inputs of one rising edge to the abstract queue model.
    task automatic model_step();
        bit   do_pop, rev, lev;
        rec_t r;
        do_pop = (m_q.size() != 0) && ev_ready;
        if (do_pop) r = m_q.pop_front();
        if (enable) begin
            rev = EDGE ? (rco && !m_prev_rco) : rco;
            lev = EDGE ? (load && !m_prev_load) : load;
            m_prev_rco  = rco;
            m_prev_load = load;
            if (rev) m_cnt = (m_cnt + 1) % 256;
            if (rev || lev) begin
                if (m_q.size() < DEPTH) begin
                    r.kind = 2 * int'(lev) + int'(rev);
                    r.q    = int'(q);
                    r.ts   = m_ts;
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1;
                end
            end
            m_ts = (m_ts + 1) % 256;
        end
    endtask

    task automatic compare_all();
        bit nonempty;
        nonempty = (m_q.size() != 0);
        check("ev_valid", ev_valid, nonempty);
        check("ev_type", ev_type, nonempty ? m_q[0].kind : 0);
        check("ev_q", ev_q, nonempty ? m_q[0].q : 0);
        check("ev_ts", ev_ts, nonempty ? m_q[0].ts : 0);
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, !nonempty);
        check("overflow", overflow, m_ovf);
        check("rco_cnt", rco_cnt, m_cnt);
    endtask

    // Drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic cycle(input logic en, input logic [3:0] qv, input logic r, input logic l,
                         input logic rdy);
        enable = en; q = qv; rco = r; load = l; ev_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int exp_ts[6];
        int c0;

        rst_n = 1'b0; enable = 0; q = 0; rco = 0; load = 0; ev_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Single RCO pulse at ts=5, consumer ready.
        repeat (5) cycle(1, 4'h0, 0, 0, 1);
        cycle(1, 4'hF, 1, 0, 1);
        check("t1_valid", ev_valid, 1);
        check("t1_type", ev_type, 2'b01);
        check("t1_q", ev_q, 4'hF);
        check("t1_ts", ev_ts, 5);
        cycle(1, 4'h0, 0, 0, 1);
        check("t1_popped", ev_valid, 0);
        check("t1_cnt", rco_cnt, 1);

        // RCO and LOAD together make one entry of type 11.
        cycle(1, 4'h3, 1, 1, 0);
        check("t2_type", ev_type, 2'b11);
        check("t2_q", ev_q, 4'h3);
        cycle(1, 4'h0, 0, 0, 1);
        check("t2_empty", empty, 1);

        // Full FIFO with a simultaneous pop accepts a new event.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 4'(i), 0, 1, 0);
            cycle(1, 4'h0, 0, 0, 0);
        end
        check("t4_full_before", full, 1);
        cycle(1, 4'h7, 1, 0, 1);
        check("t4_full_after", full, 1);
        check("t4_no_overflow", overflow, 0);
        repeat (DEPTH) cycle(1, 4'h0, 0, 0, 1);
        check("t4_drained", empty, 1);

        // RCO held high for three enabled cycles.
        c0 = int'(rco_cnt);
        repeat (3) cycle(1, 4'h9, 1, 0, 0);
        cycle(1, 4'h0, 0, 0, 0);
        check("t5_cnt_delta", 32'((int'(rco_cnt) - c0 + 256) % 256), EDGE ? 1 : 3);
        repeat (DEPTH) cycle(1, 4'h0, 0, 0, 1);

        // Six LOAD pulses into a stalled FIFO: four stored, later ones dropped.
        c0 = int'(rco_cnt);
        for (int i = 0; i < 6; i++) begin
            exp_ts[i] = m_ts;
            cycle(1, 4'(i + 1), 0, 1, 0);
            if (i == 3) check("t3_full", full, 1);
            if (i == 4) check("t3_overflow", overflow, 1);
            cycle(1, 4'h0, 0, 0, 0);
        end
        check("t3_cnt_same", rco_cnt, c0);
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_drain_ts", ev_ts, exp_ts[i]);
            cycle(1, 4'h0, 0, 0, 1);
        end
        check("t3_empty", empty, 1);

        // Two entries plus sticky overflow, then reset asserted mid-cycle.
        cycle(1, 4'h1, 0, 1, 0);
        cycle(1, 4'h0, 0, 0, 0);
        cycle(1, 4'h2, 0, 1, 0);
        cycle(1, 4'h0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", ev_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cnt", rco_cnt, 0);
        check("rst_ts_out", ev_ts, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 4'h5, 0, 1, 0);
        check("rst_first_ts", ev_ts, 0);
        cycle(1, 4'h0, 0, 0, 1);

        // Random traffic, long enough for the timestamp to wrap.
        for (int i = 0; i < 900; i++) begin
            cycle($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
